// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   - opcode field values seen on op (instr[31:26])
//   - default reset PC and the NOP word driven when no instruction is valid
//   - fetch FSM state encoding
package instr_fetch_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

  // Word-align a byte address.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/instr_fetch_flopenr.sv
// Enabled register with synchronous active-low reset.
//   clk   in  1      rising-edge clock
//   reset in  1      synchronous, active-low; loads RESET_VAL
//   en    in  1      load d when high
//   d     in  WIDTH  next value
//   q     out WIDTH  registered value
module instr_fetch_flopenr #(
  parameter int          WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!reset)  q <= RESET_VAL;
    else if (en) q <= d;
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage feeding the main decoder.
// Holds the PC, requests words from instruction memory over a req/ack
// handshake and latches the returned word into the instruction register.
//   clk          in   1   rising-edge clock
//   reset        in   1   synchronous, active-low
//   imem_req     out  1   fetch request, held until imem_ack
//   imem_addr    out  32  request address, stable while imem_req=1
//   imem_ack     in   1   imem_rdata valid this cycle
//   imem_rdata   in   32  returned instruction word
//   stall        in   1   decode cannot accept; hold current instruction
//   redirect     in   1   taken branch/jump, overrides stall and ack
//   redirect_pc  in   32  new fetch PC (low two bits ignored)
//   instr        out  32  instruction register (NOP_INSTR when invalid)
//   instr_pc     out  32  PC of instr
//   pcplus4      out  32  instr_pc + 4 (wraps)
//   op           out  6   instr[31:26]
//   instr_valid  out  1   instr/instr_pc/op meaningful
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pcplus4,
  output logic [5:0]  op,
  output logic        instr_valid
);

  fetch_state_e state_q, state_d;

  logic [31:0] pc_q, pc_d;
  logic [31:0] fa_q, fa_d;
  logic [31:0] ir_d, ipc_d;
  logic        pc_en, fa_en, ir_en, ipc_en;
  logic        vld_d;
  logic [31:0] target;

  instr_fetch_flopenr #(.WIDTH(32), .RESET_VAL(RESET_PC)) u_pc (
    .clk(clk), .reset(reset), .en(pc_en), .d(pc_d), .q(pc_q));

  instr_fetch_flopenr #(.WIDTH(32), .RESET_VAL(RESET_PC)) u_fetch_addr (
    .clk(clk), .reset(reset), .en(fa_en), .d(fa_d), .q(fa_q));

  instr_fetch_flopenr #(.WIDTH(32), .RESET_VAL(NOP_INSTR)) u_instr (
    .clk(clk), .reset(reset), .en(ir_en), .d(ir_d), .q(instr));

  instr_fetch_flopenr #(.WIDTH(32), .RESET_VAL(RESET_PC)) u_instr_pc (
    .clk(clk), .reset(reset), .en(ipc_en), .d(ipc_d), .q(instr_pc));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= FETCH;
      instr_valid <= 1'b0;
    end else begin
      state_q     <= state_d;
      instr_valid <= vld_d;
    end
  end

  assign target    = word_align(redirect_pc);
  assign imem_addr = fa_q;
  // Reset is folded in combinationally so a pending request drops immediately.
  assign imem_req  = reset && (state_q == FETCH || state_q == FLUSH);
  assign pcplus4   = instr_pc + 32'd4;
  assign op        = instr[31:26];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pc_en   = 1'b0;
    fa_d    = fa_q;
    fa_en   = 1'b0;
    ir_d    = instr;
    ir_en   = 1'b0;
    ipc_d   = instr_pc;
    ipc_en  = 1'b0;
    vld_d   = instr_valid;

    if (redirect) begin
      pc_d  = target;
      pc_en = 1'b1;
      ir_d  = NOP_INSTR;
      ir_en = 1'b1;
      vld_d = 1'b0;
      case (state_q)
        FETCH: begin
          if (imem_ack) begin
            // Handshake already closed this cycle: restart at the target.
            fa_d    = target;
            fa_en   = 1'b1;
            state_d = FETCH;
          end else begin
            // Request is in flight; keep its address until memory answers.
            state_d = FLUSH;
          end
        end
        FLUSH: state_d = FLUSH;
        HOLD: begin
          fa_d    = target;
          fa_en   = 1'b1;
          state_d = FETCH;
        end
        default: begin
          fa_d    = target;
          fa_en   = 1'b1;
          state_d = FETCH;
        end
      endcase
    end else begin
      case (state_q)
        FETCH: begin
          if (imem_ack) begin
            ir_d    = imem_rdata;
            ir_en   = 1'b1;
            ipc_d   = fa_q;
            ipc_en  = 1'b1;
            vld_d   = 1'b1;
            pc_d    = fa_q + 32'd4;
            pc_en   = 1'b1;
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (!stall) begin
            ir_d    = NOP_INSTR;
            ir_en   = 1'b1;
            vld_d   = 1'b0;
            fa_d    = pc_q;
            fa_en   = 1'b1;
            state_d = FETCH;
          end
        end
        FLUSH: begin
          // Abandoned fetch completes; its data is dropped.
          if (imem_ack) begin
            fa_d    = pc_q;
            fa_en   = 1'b1;
            state_d = FETCH;
          end
        end
        default: begin
          fa_d    = pc_q;
          fa_en   = 1'b1;
          state_d = FETCH;
        end
      endcase
    end
  end

endmodule
